// File: rtl/myproject_mul_pipe_sat.sv
// Pipelined fixed-point multiplier: operand extension, exact product,
// rescale (round/floor), narrow (saturate/wrap) with a valid token and ce stalls.
// Ports:
//   clk, reset (async, active high), ce (advance enable)
//   in_valid, din0, din1         : sample in
//   clr_ovf                      : clear ovf_sticky (independent of ce)
//   out_valid, dout, ovf         : result out
//   ovf_sticky                   : OR of ovf over valid results since reset/clear
module myproject_mul_pipe_sat #(
    parameter int DIN0_WIDTH  = 13,
    parameter int DIN1_WIDTH  = 6,
    parameter int DOUT_WIDTH  = 18,
    parameter int DIN0_SIGNED = 1,
    parameter int DIN1_SIGNED = 0,
    parameter int NUM_STAGE   = 2,
    parameter int SHIFT       = 0,
    parameter int ROUND       = 0,
    parameter int SAT         = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    input  logic                  clr_ovf,
    output logic                  out_valid,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  ovf,
    output logic                  ovf_sticky
);

    localparam int AW = DIN0_WIDTH + 1;
    localparam int BW = DIN1_WIDTH + 1;
    localparam int PW = AW + BW;
    localparam int RW = PW + 1;
    localparam int DW = DOUT_WIDTH;
    // registers after the narrowing logic; the last one drives the outputs
    localparam int ND = (NUM_STAGE > 2) ? NUM_STAGE - 2 : 1;
    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam bit DO_RND = (ROUND != 0) && (SHIFT > 0);
    localparam logic signed [RW-1:0] RND =
        $signed({{(RW-1){1'b0}}, DO_RND} << RSH);

    if (NUM_STAGE < 1 || NUM_STAGE > 4) begin : g_bad_ns
        $error("myproject_mul_pipe_sat: NUM_STAGE must be 1..4");
    end
    if (SHIFT < 0 || SHIFT > DIN0_WIDTH + DIN1_WIDTH) begin : g_bad_sh
        $error("myproject_mul_pipe_sat: SHIFT out of range");
    end

    logic signed [AW-1:0] w_a_ext;
    logic signed [BW-1:0] w_b_ext;
    logic signed [AW-1:0] w_mul_a;
    logic signed [BW-1:0] w_mul_b;
    logic                 w_mul_v;
    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] w_sc_p;
    logic                 w_sc_v;
    logic signed [RW-1:0] w_px;
    logic signed [RW-1:0] w_rsum;
    logic signed [RW-1:0] w_r;
    logic        [DW-1:0] w_nd;
    logic                 w_novf;
    logic                 w_lv;
    logic                 w_lo;

    logic                 r_dv [ND];
    logic        [DW-1:0] r_dd [ND];
    logic                 r_do [ND];

    assign w_a_ext = (DIN0_SIGNED != 0) ?
        $signed({din0[DIN0_WIDTH-1], din0}) : $signed({1'b0, din0});
    assign w_b_ext = (DIN1_SIGNED != 0) ?
        $signed({din1[DIN1_WIDTH-1], din1}) : $signed({1'b0, din1});

    // stage 1: extended operands
    if (NUM_STAGE == 1) begin : g_s1
        assign w_mul_a = w_a_ext;
        assign w_mul_b = w_b_ext;
        assign w_mul_v = in_valid;
    end else begin : g_s1
        logic signed [AW-1:0] r_a;
        logic signed [BW-1:0] r_b;
        logic                 r_v1;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_a  <= '0;
                r_b  <= '0;
                r_v1 <= 1'b0;
            end else if (ce) begin
                r_a  <= w_a_ext;
                r_b  <= w_b_ext;
                r_v1 <= in_valid;
            end
        end
        assign w_mul_a = r_a;
        assign w_mul_b = r_b;
        assign w_mul_v = r_v1;
    end

    // both factors widened to PW so the product is exact
    assign w_prod = $signed({{BW{w_mul_a[AW-1]}}, w_mul_a})
                  * $signed({{AW{w_mul_b[BW-1]}}, w_mul_b});

    // stage 2 (deep pipelines only): registered product
    if (NUM_STAGE >= 3) begin : g_s2
        logic signed [PW-1:0] r_p;
        logic                 r_v2;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_p  <= '0;
                r_v2 <= 1'b0;
            end else if (ce) begin
                r_p  <= w_prod;
                r_v2 <= w_mul_v;
            end
        end
        assign w_sc_p = r_p;
        assign w_sc_v = r_v2;
    end else begin : g_s2
        assign w_sc_p = w_prod;
        assign w_sc_v = w_mul_v;
    end

    // one extra bit keeps the rounding add from overflowing
    assign w_px   = {w_sc_p[PW-1], w_sc_p};
    assign w_rsum = w_px + RND;
    assign w_r    = w_rsum >>> SHIFT;

    if (DW >= RW) begin : g_nar
        assign w_nd   = DW'(w_r);
        assign w_novf = 1'b0;
    end else begin : g_nar
        // in range iff the bits above the result sign all equal it
        logic [RW-DW:0] w_hi;
        assign w_hi   = w_r[RW-1:DW-1];
        assign w_novf = ~((&w_hi) | (~|w_hi));
        if (SAT != 0) begin : g_sat
            assign w_nd = !w_novf ? w_r[DW-1:0] :
                          w_r[RW-1] ? {1'b1, {(DW-1){1'b0}}} :
                                      {1'b0, {(DW-1){1'b1}}};
        end else begin : g_sat
            assign w_nd = w_r[DW-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ND; i++) begin
                r_dv[i] <= 1'b0;
                r_dd[i] <= '0;
                r_do[i] <= 1'b0;
            end
        end else if (ce) begin
            r_dv[0] <= w_sc_v;
            r_dd[0] <= w_nd;
            r_do[0] <= w_novf;
            for (int i = 1; i < ND; i++) begin
                r_dv[i] <= r_dv[i-1];
                r_dd[i] <= r_dd[i-1];
                r_do[i] <= r_do[i-1];
            end
        end
    end

    // valid/ovf about to land in the output register this edge
    if (ND == 1) begin : g_look
        assign w_lv = w_sc_v;
        assign w_lo = w_novf;
    end else begin : g_look
        assign w_lv = r_dv[ND-2];
        assign w_lo = r_do[ND-2];
    end

    // a new overflow beats a simultaneous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_sticky <= 1'b0;
        end else if (ce && w_lv && w_lo) begin
            ovf_sticky <= 1'b1;
        end else if (clr_ovf) begin
            ovf_sticky <= 1'b0;
        end
    end

    assign out_valid = r_dv[ND-1];
    assign dout      = r_dd[ND-1];
    assign ovf       = r_do[ND-1];

endmodule

// File: tb/tb_myproject_mul_pipe_sat.sv
// Scoreboard bench for myproject_mul_pipe_sat over a set of configurations.
// Shared random stimulus; each instance keeps its own expected-result queue.
module tb_myproject_mul_pipe_sat;

    localparam int NI = 20;

    typedef struct {
        longint tag;
        longint d;
        bit     o;
    } item_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b0;
    logic        in_valid = 1'b0;
    logic [12:0] din0 = '0;
    logic [5:0]  din1 = '0;
    logic        clr_ovf = 1'b0;

    logic        w_ov  [NI];
    logic [17:0] w_dout[NI];
    logic        w_of  [NI];
    logic        w_stk [NI];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          pending = 0;
    longint      edge_n = 0;
    logic [12:0] s_a;
    logic [5:0]  s_b;
    longint      s_tag;
    event        ev_issue;

    initial forever #5 clk = ~clk;

    // counts ce-enabled edges outside reset
    initial forever begin
        @(posedge clk);
        if (ce && !reset) edge_n++;
    end

    task automatic chk(input int id, input string nm,
                       input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s inst%0d t=%0t got=%0d want=%0d",
                     nm, id, $time, act, exp);
        end
    endtask

    // reference: plain integer arithmetic from the operand interpretation
    function automatic item_t mdl(input logic [12:0] a, input logic [5:0] b,
                                  input int s0, input int s1, input int sh,
                                  input int rd, input int sat,
                                  input longint tag);
        longint av, bv, p, r, w;
        item_t  it;
        av = (s0 != 0) ? longint'($signed(a)) : longint'(a);
        bv = (s1 != 0) ? longint'($signed(b)) : longint'(b);
        p  = av * bv;
        if (sh > 0 && rd != 0) p = p + (longint'(1) << (sh - 1));
        r  = p >>> sh;
        it.o = (r > 131071) || (r < -131072);
        if (sat != 0) begin
            w = (r > 131071) ? 131071 : ((r < -131072) ? -131072 : r);
        end else begin
            w = r & 64'h3FFFF;
            if (w >= 131072) w = w - 262144;
        end
        it.d   = w;
        it.tag = tag;
        return it;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_i
        localparam int NS = (g < 16) ? g / 4 + 1 : ((g == 19) ? 3 : 2);
        localparam int S0 = (g < 16) ? (g % 4) / 2 : 1;
        localparam int S1 = (g < 16) ? g % 2 : ((g >= 17) ? 1 : 0);
        localparam int SH = (g == 17 || g == 18) ? 2 : ((g == 19) ? 3 : 0);
        localparam int RD = (g == 17 || g == 19) ? 1 : 0;
        localparam int ST = (g == 16 || g == 19) ? 0 : 1;

        myproject_mul_pipe_sat #(
            .DIN0_WIDTH(13), .DIN1_WIDTH(6), .DOUT_WIDTH(18),
            .DIN0_SIGNED(S0), .DIN1_SIGNED(S1), .NUM_STAGE(NS),
            .SHIFT(SH), .ROUND(RD), .SAT(ST)
        ) u_dut (
            .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
            .din0(din0), .din1(din1), .clr_ovf(clr_ovf),
            .out_valid(w_ov[g]), .dout(w_dout[g]), .ovf(w_of[g]),
            .ovf_sticky(w_stk[g])
        );

        item_t  q[$];
        item_t  pe;
        item_t  e;
        bit     last_v = 1'b0;
        bit     last_o = 1'b0;
        bit     stk = 1'b0;
        longint last_d = 0;
        bit     c, clr_s, r_s, hit;

        initial forever begin
            @(ev_issue);
            pe = mdl(s_a, s_b, S0, S1, SH, RD, ST, s_tag);
            q.push_back(pe);
            pending++;
        end

        initial forever begin
            @(posedge reset);
            pending = pending - q.size();
            q.delete();
            last_v = 1'b0;
            stk = 1'b0;
            #1;
            chk(g, "async_rst_valid", longint'(w_ov[g]), 0);
            chk(g, "async_rst_dout", longint'(w_dout[g]), 0);
        end

        initial forever begin
            @(posedge clk);
            c     = ce && !reset;
            clr_s = clr_ovf;
            r_s   = reset;
            #1;
            if (r_s) begin
                chk(g, "rst_valid", longint'(w_ov[g]), 0);
                chk(g, "rst_dout", longint'(w_dout[g]), 0);
                chk(g, "rst_ovf", longint'(w_of[g]), 0);
                chk(g, "rst_sticky", longint'(w_stk[g]), 0);
            end else begin
                hit = 1'b0;
                if (c) begin
                    while (q.size() > 0 && q[0].tag + NS - 1 < edge_n) begin
                        chk(g, "lost_sample", q[0].tag + NS - 1, edge_n);
                        void'(q.pop_front());
                        pending--;
                    end
                    if (q.size() > 0 && q[0].tag + NS - 1 == edge_n) begin
                        e = q.pop_front();
                        pending--;
                        hit = 1'b1;
                        chk(g, "out_valid", longint'(w_ov[g]), 1);
                        chk(g, "dout", longint'($signed(w_dout[g])), e.d);
                        chk(g, "ovf", longint'(w_of[g]), longint'(e.o));
                        last_v = 1'b1;
                        last_d = e.d;
                        last_o = e.o;
                    end else begin
                        chk(g, "bubble_valid", longint'(w_ov[g]), 0);
                        last_v = 1'b0;
                    end
                end else begin
                    chk(g, "hold_valid", longint'(w_ov[g]), longint'(last_v));
                    if (last_v) begin
                        chk(g, "hold_dout", longint'($signed(w_dout[g])), last_d);
                        chk(g, "hold_ovf", longint'(w_of[g]), longint'(last_o));
                    end
                end
                stk = (hit && e.o) ? 1'b1 : (clr_s ? 1'b0 : stk);
                chk(g, "sticky", longint'(w_stk[g]), longint'(stk));
            end
        end
    end

    task automatic drive(input logic [12:0] a, input logic [5:0] b,
                         input bit v, input bit c, input bit clr);
        @(negedge clk);
        din0     = a;
        din1     = b;
        in_valid = v;
        ce       = c;
        clr_ovf  = clr;
        if (c && v) begin
            s_a   = a;
            s_b   = b;
            s_tag = edge_n + 1;
            -> ev_issue;
        end
    endtask

    function automatic logic [12:0] pick_a();
        logic [12:0] ex [4];
        ex = '{13'h1000, 13'h0FFF, 13'h1FFF, 13'h0000};
        if ($urandom_range(0, 9) == 0) return ex[$urandom_range(0, 3)];
        return 13'($urandom);
    endfunction

    function automatic logic [5:0] pick_b();
        logic [5:0] ex [4];
        ex = '{6'h20, 6'h1F, 6'h3F, 6'h00};
        if ($urandom_range(0, 9) == 0) return ex[$urandom_range(0, 3)];
        return 6'($urandom);
    endfunction

    initial begin
        int pat [7];
        int n;
        int k;
        pat = '{1, 0, 0, 1, 1, 0, 1};

        repeat (3) @(negedge clk);
        reset = 1'b0;

        drive(13'd100, 6'd5, 1, 1, 0);
        drive(13'h1000, 6'd63, 1, 1, 0);
        repeat (4) drive(13'd0, 6'd0, 0, 1, 0);
        drive(13'd0, 6'd0, 0, 1, 1);
        drive(13'd0, 6'd0, 0, 1, 0);
        drive(13'd5, 6'd2, 1, 1, 0);
        drive(13'h1FFB, 6'd2, 1, 1, 0);
        repeat (4) drive(13'd0, 6'd0, 0, 1, 0);

        n = 0;
        k = 0;
        while (n < 8) begin
            drive(pick_a(), pick_b(), 1, pat[k % 7] != 0, 0);
            if (pat[k % 7] != 0) n++;
            k++;
        end
        repeat (5) drive(13'd0, 6'd0, 0, 1, 0);

        drive(pick_a(), pick_b(), 1, 1, 0);
        drive(pick_a(), pick_b(), 1, 1, 0);
        @(posedge clk);
        #2;
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) drive(13'd0, 6'd0, 0, 1, 0);
        drive(pick_a(), pick_b(), 1, 1, 0);
        repeat (5) drive(13'd0, 6'd0, 0, 1, 0);

        for (int i = 0; i < 1600; i++) begin
            drive(pick_a(), pick_b(), $urandom_range(0, 9) < 8,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        end
        repeat (8) drive(13'd0, 6'd0, 0, 1, 0);
        @(negedge clk);

        chk(-1, "scoreboard_drained", longint'(pending), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
